dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port (synchronous 1-cycle read, byte write enables, load_select extension) between two requesters.
- m0 is the CPU load/store unit; m1 is the debug/DMA loader.
- Round-robin arbitration, with an optional bounded lock for atomic multi-beat sequences.
- Pipelined: one grant per cycle; read data returns to the granted requester one cycle later.

Parameters:
- ADDR_W, 32, address width of requesters and memory port
- DATA_W, 32, data width
- MAX_BURST, 4, max consecutive grants a locked requester may hold (>=1)
- CNT_W, 3, width of burst counter; must satisfy 2^CNT_W > MAX_BURST

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mN_req  in  1  request (N=0,1), held until granted
- mN_lock  in  1  request continued ownership after this beat
- mN_we  in  4  byte write enables (0 = read)
- mN_load_select  in  3  load extension code, passed through
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  write data
- mN_gnt  out  1  beat accepted this cycle (combinational)
- mN_rvalid  out  1  read data valid (registered)
- mN_rdata  out  DATA_W  = mem_rdata, qualified by mN_rvalid
- mem_rd  out  1  memory enable; high for reads and writes
- mem_we  out  4  byte enables to memory
- mem_load_select  out  3  to memory
- mem_addr  out  ADDR_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_rdata  in  DATA_W  memory output, valid cycle after mem_rd

Behaviour:
- Reset values:
  - gnt=0, rvalid=0, mem_rd=0, mem_we=0, other mem_* outputs 0.
  - FSM=IDLE, last_gnt=1 (m0 wins the first tie), burst_cnt=0.
- FSM states IDLE, LOCK0, LOCK1:
  - IDLE, single req: grant it.
  - IDLE, both req: grant !last_gnt.
  - IDLE, granted beat has lock=1 and MAX_BURST>1: go to LOCKn, burst_cnt=1.
  - LOCKn: only mN can be granted; the other requester's gnt is forced 0.
  - LOCKn, granted beat with lock=0: go to IDLE.
  - LOCKn, granted beat that makes burst_cnt==MAX_BURST: forced release to IDLE, last_gnt=n, so the other side wins the next tie.
  - LOCKn, mN_req low: stay LOCKn; no grant issued; burst_cnt unchanged.
  - LOCKn, mN_lock low with no req: go to IDLE.
- last_gnt updates on every grant.
- Mux:
  - While mN_gnt is high: mem_* = mN_*, mem_rd=1.
  - No grant: mem_rd=0 and mem_we=0; addr, wdata and load_select hold the last values.
- Response: mN_rvalid=1 the cycle after a granted beat with we==0; never for writes. Back-to-back grants produce back-to-back rvalid.
- gnt is combinational from req, FSM and last_gnt; all other state is registered. Requester inputs are not registered (zero added latency).
- At most one gnt is high per cycle.
- Reset asserted mid-operation: an in-flight rvalid is dropped and lock is abandoned. Requesters must reissue.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_gnt0, stat_gnt1 (16-bit, count grants per requester) and stat_conflict (16-bit, counts cycles with both req high and one gnt blocked).
  - All three counters saturate at 16'hFFFF and reset to 0.
  - Adds input stat_clr (1), a synchronous clear that takes priority over increment.
- Not defined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then m0 read addr 0x80000010 with memory preloaded 0xDEADBEEF -> m0_gnt same cycle, m0_rvalid next cycle, m0_rdata=0xDEADBEEF, m1 outputs 0.
- Both req held for 6 cycles, no lock -> grants alternate m0,m1,m0,m1,m0,m1; rvalid follows each grant by 1 cycle.
- m1 lock=1 for 6 beats while m0 req held, MAX_BURST=4 -> m1 gets 4 consecutive grants, then m0 granted, then m1.
- m0 write we=4'b0011 data 0x12345678 to 0x80000020, then read -> mem_rd=1 on the write beat, no rvalid on the write; readback lower half = 0x5678.
- rst asserted the cycle after an m0 read grant -> m0_rvalid stays 0, FSM=IDLE, next tie granted to m0.
- With DMEM_ARB_STATS_EN: 5 contention cycles, then stat_clr -> stat_conflict=5 before clear, 0 after.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the data-memory port: m0 is the CPU LSU, m1 the debug/DMA loader.
// Round-robin with a bounded lock for atomic bursts; optional grant/conflict counters (DMEM_ARB_STATS_EN).
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   mN_req/lock/we      request, hold-ownership flag, byte write enables (0 = read)
//   mN_load_select      load extension code passed through to memory
//   mN_addr/wdata       byte address and write data
//   mN_gnt              beat accepted this cycle (combinational)
//   mN_rvalid/rdata     read response, one cycle after a granted read
//   mem_*               shared synchronous memory port (1-cycle read latency)
//   stat_* (optional)   saturating 16-bit grant/conflict counters, stat_clr clears
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_lock,
  input  logic [3:0]        m0_we,
  input  logic [2:0]        m0_load_select,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic [3:0]        m1_we,
  input  logic [2:0]        m1_load_select,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_rd,
  output logic [3:0]        mem_we,
  output logic [2:0]        mem_load_select,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
  input  logic              stat_clr,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic [15:0]       stat_conflict,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_BURST);
  localparam logic LP_LOCK_EN = (MAX_BURST > 1);
  localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

  state_t r_state;
  state_t w_state_nxt;

  // r_last_gnt = index of the most recently granted requester;
  // the other one wins the next tie.
  logic             r_last_gnt;
  logic             w_last_nxt;
  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;

  logic w_gnt0;
  logic w_gnt1;
  logic w_any;

  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_ls;

  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic [2:0]        w_sel_ls;
  logic [3:0]        w_sel_we;

  assign w_cnt_inc = r_burst_cnt + LP_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last_gnt  <= 1'b1;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_gnt  <= w_last_nxt;
      r_burst_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_burst_cnt;
    w_last_nxt  = r_last_gnt;

    unique case (r_state)
      S_IDLE: begin
        if (m0_req && m1_req) begin
          w_gnt0 = r_last_gnt;
          w_gnt1 = !r_last_gnt;
        end else begin
          w_gnt0 = m0_req;
          w_gnt1 = m1_req;
        end
        if (w_gnt0 && m0_lock && LP_LOCK_EN) begin
          w_state_nxt = S_LOCK0;
          w_cnt_nxt   = LP_ONE;
        end else if (w_gnt1 && m1_lock && LP_LOCK_EN) begin
          w_state_nxt = S_LOCK1;
          w_cnt_nxt   = LP_ONE;
        end
      end

      S_LOCK0: begin
        w_gnt0 = m0_req;
        if (m0_req) begin
          // Owner drops lock or hits the burst cap: hand back to round-robin.
          if (!m0_lock || (w_cnt_inc == LP_MAX)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else if (!m0_lock) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end

      S_LOCK1: begin
        w_gnt1 = m1_req;
        if (m1_req) begin
          if (!m1_lock || (w_cnt_inc == LP_MAX)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else if (!m1_lock) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    if (w_gnt0) begin
      w_last_nxt = 1'b0;
    end else if (w_gnt1) begin
      w_last_nxt = 1'b1;
    end
  end

  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;
  assign w_any  = w_gnt0 | w_gnt1;

  assign w_sel_addr  = w_gnt1 ? m1_addr : m0_addr;
  assign w_sel_wdata = w_gnt1 ? m1_wdata : m0_wdata;
  assign w_sel_ls    = w_gnt1 ? m1_load_select : m0_load_select;
  assign w_sel_we    = w_gnt1 ? m1_we : m0_we;

  // Address/data/load_select hold the last granted beat between grants
  // so the memory inputs do not toggle while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_ls    <= '0;
    end else if (w_any) begin
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
      r_ls    <= w_sel_ls;
    end
  end

  assign mem_rd          = w_any;
  assign mem_we          = w_any ? w_sel_we : 4'b0000;
  assign mem_addr        = w_any ? w_sel_addr : r_addr;
  assign mem_wdata       = w_any ? w_sel_wdata : r_wdata;
  assign mem_load_select = w_any ? w_sel_ls : r_ls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 && (m0_we == 4'b0000);
      r_rvalid1 <= w_gnt1 && (m1_we == 4'b0000);
    end
  end

  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rvalid0 ? mem_rdata : '0;
  assign m1_rdata  = r_rvalid1 ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_stat_gnt0;
  logic [15:0] r_stat_gnt1;
  logic [15:0] r_stat_conf;
  logic        w_conflict;

  // Both requesting always leaves one of them blocked.
  assign w_conflict = m0_req && m1_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_gnt0 <= '0;
      r_stat_gnt1 <= '0;
      r_stat_conf <= '0;
    end else if (stat_clr) begin
      r_stat_gnt0 <= '0;
      r_stat_gnt1 <= '0;
      r_stat_conf <= '0;
    end else begin
      if (w_gnt0 && (r_stat_gnt0 != 16'hFFFF)) begin
        r_stat_gnt0 <= r_stat_gnt0 + 16'd1;
      end
      if (w_gnt1 && (r_stat_gnt1 != 16'hFFFF)) begin
        r_stat_gnt1 <= r_stat_gnt1 + 16'd1;
      end
      if (w_conflict && (r_stat_conf != 16'hFFFF)) begin
        r_stat_conf <= r_stat_conf + 16'd1;
      end
    end
  end

  assign stat_gnt0     = r_stat_gnt0;
  assign stat_gnt1     = r_stat_gnt1;
  assign stat_conflict = r_stat_conf;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares whenever the DUT grants or returns data.
module tb_dmem_arbiter;

  localparam logic [31:0] A4 = 32'h8000_0010;
  localparam logic [31:0] A5 = 32'h8000_0014;
  localparam logic [31:0] A8 = 32'h8000_0020;
  localparam logic [31:0] D4 = 32'hDEAD_BEEF;
  localparam logic [31:0] D5 = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_lock, m1_req, m1_lock;
  logic [3:0]  m0_we, m1_we;
  logic [2:0]  m0_ls, m1_ls;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_rd;
  logic [3:0]  mem_we;
  logic [2:0]  mem_ls;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_we(m0_we),
    .m0_load_select(m0_ls), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_we(m1_we),
    .m1_load_select(m1_ls), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_load_select(mem_ls),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_STATS_EN
    .stat_clr(stat_clr), .stat_gnt0(stat_gnt0),
    .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict),
`endif
    .mem_rdata(mem_rdata)
  );

  // Synchronous 1-cycle-read memory with byte enables.
  logic [31:0] mem [0:63];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[4]    <= D4;
      mem[5]    <= D5;
      mem[8]    <= 32'hFFFF_0000;
      mem_rdata <= 32'h0;
    end else if (mem_rd) begin
      if (mem_we == 4'b0000) begin
        mem_rdata <= mem[mem_addr[7:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  typedef struct {
    int          who;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } g_t;
  typedef struct {
    int          who;
    logic [31:0] data;
  } r_t;

  g_t gq[$];
  r_t rq[$];
  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT grants or responds.
  always @(negedge clk) begin
    g_t g;
    r_t r;
    if (!rst) begin
      chk("one_gnt", 32'(m0_gnt & m1_gnt), 32'd0);
      chk("one_rvalid", 32'(m0_rvalid & m1_rvalid), 32'd0);
      if (m0_gnt || m1_gnt) begin
        if (gq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexp_gnt: got m0=%0b m1=%0b expected none",
                   m0_gnt, m1_gnt);
        end else begin
          g = gq.pop_front();
          chk("gnt_who", m1_gnt ? 32'd2 : 32'd1, 32'(g.who));
          chk("gnt_mem_rd", 32'(mem_rd), 32'd1);
          chk("gnt_addr", mem_addr, g.addr);
          chk("gnt_we", 32'(mem_we), 32'(g.we));
          chk("gnt_wdata", mem_wdata, g.wdata);
        end
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexp_rvalid: got m0=%0b m1=%0b expected none",
                   m0_rvalid, m1_rvalid);
        end else begin
          r = rq.pop_front();
          chk("rv_who", m1_rvalid ? 32'd2 : 32'd1, 32'(r.who));
          chk("rv_data", m1_rvalid ? m1_rdata : m0_rdata, r.data);
          chk("rv_other", m1_rvalid ? m0_rdata : m1_rdata, 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_ls = 0;
    m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_ls = 0;
    m1_addr = 0; m1_wdata = 0;
`ifdef DMEM_ARB_STATS_EN
    stat_clr = 0;
`endif
  endtask

  task automatic rd0(input logic [31:0] a, input logic lk);
    m0_req = 1; m0_lock = lk; m0_we = 0; m0_addr = a; m0_wdata = 0;
  endtask

  task automatic rd1(input logic [31:0] a, input logic lk);
    m1_req = 1; m1_lock = lk; m1_we = 0; m1_addr = a; m1_wdata = 0;
  endtask

  task automatic eg(input int who, input logic [31:0] a,
                    input logic [3:0] we, input logic [31:0] wd);
    g_t g;
    g.who = who; g.addr = a; g.we = we; g.wdata = wd;
    gq.push_back(g);
  endtask

  task automatic er(input int who, input logic [31:0] d);
    r_t r;
    r.who = who; r.data = d;
    rq.push_back(r);
  endtask

  // Expected read beat for requester who (m0 reads A4, m1 reads A5).
  task automatic ebeat(input int who);
    eg(who, (who == 1) ? A4 : A5, 4'b0000, 32'h0);
    er(who, (who == 1) ? D4 : D5);
  endtask

  int seq2 [6] = '{1, 2, 1, 2, 1, 2};
  int seq3 [6] = '{2, 2, 2, 2, 1, 2};
  int seqs [5] = '{2, 1, 2, 1, 2};

  initial begin
    idle_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    chk("rst_gnt0", 32'(m0_gnt), 32'd0);
    chk("rst_gnt1", 32'(m1_gnt), 32'd0);
    chk("rst_rvalid", 32'({m0_rvalid, m1_rvalid}), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_ls", 32'(mem_ls), 32'd0);

    // Single m0 read
    tick();
    rd0(A4, 0);
    ebeat(1);
    tick();
    idle_in();
    tick();
    tick();

    // Fresh reset, then both requesting: strict alternation from m0
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      rd0(A4, 0);
      rd1(A5, 0);
      ebeat(seq2[i]);
      tick();
    end
    idle_in();
    tick();

    // m1 locked burst capped at MAX_BURST=4 while m0 waits
    rd0(A4, 0);
    ebeat(1);
    tick();
    for (int i = 0; i < 6; i++) begin
      rd0(A4, 0);
      rd1(A5, 1);
      ebeat(seq3[i]);
      tick();
    end
    idle_in();
    tick();

    // m0 locked, req low with lock high: nobody is granted
    rd0(A4, 1);
    ebeat(1);
    tick();
    m0_req = 0;
    rd1(A5, 0);
    tick();
    tick();
    rd0(A4, 0);
    ebeat(1);
    tick();
    m0_req = 0;
    ebeat(2);
    tick();
    idle_in();
    tick();

    // Partial write, hold check, readback
    m0_req = 1; m0_we = 4'b0011; m0_addr = A8;
    m0_wdata = 32'h1234_5678; m0_ls = 3'b101;
    eg(1, A8, 4'b0011, 32'h1234_5678);
    tick();
    idle_in();
    @(negedge clk);
    chk("hold_mem_rd", 32'(mem_rd), 32'd0);
    chk("hold_mem_we", 32'(mem_we), 32'd0);
    chk("hold_addr", mem_addr, A8);
    chk("hold_wdata", mem_wdata, 32'h1234_5678);
    chk("hold_ls", 32'(mem_ls), 32'd5);
    tick();
    rd0(A8, 0);
    eg(1, A8, 4'b0000, 32'h0);
    er(1, 32'hFFFF_5678);
    tick();
    idle_in();
    tick();
    tick();

    // Reset right after an m0 read grant drops the response
    rd0(A4, 0);
    eg(1, A4, 4'b0000, 32'h0);
    tick();
    rst = 1;
    idle_in();
    @(negedge clk);
    chk("rst_drop_rvalid", 32'(m0_rvalid), 32'd0);
    tick();
    rst = 0;
    rd0(A4, 0);
    rd1(A5, 0);
    ebeat(1);
    tick();
    idle_in();
    tick();
    tick();

`ifdef DMEM_ARB_STATS_EN
    stat_clr = 1;
    tick();
    stat_clr = 0;
    for (int i = 0; i < 5; i++) begin
      rd0(A4, 0);
      rd1(A5, 0);
      ebeat(seqs[i]);
      tick();
    end
    idle_in();
    @(negedge clk);
    chk("stat_conflict", 32'(stat_conflict), 32'd5);
    chk("stat_gnt0", 32'(stat_gnt0), 32'd2);
    chk("stat_gnt1", 32'(stat_gnt1), 32'd3);
    tick();
    stat_clr = 1;
    rd0(A4, 0);
    rd1(A5, 0);
    ebeat(1);
    tick();
    idle_in();
    @(negedge clk);
    chk("stat_clr_conf", 32'(stat_conflict), 32'd0);
    chk("stat_clr_gnt0", 32'(stat_gnt0), 32'd0);
    tick();
    tick();
`endif

    tick();
    tick();
    chk("gnt_q_empty", 32'(gq.size()), 32'd0);
    chk("rd_q_empty", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
